// File: rtl/rvfi_check_pkg.sv
// Shared types and helpers for the RVFI causality checker: FSM state encoding,
// hit-vector sizing, and small bit-counting functions.
package rvfi_check_pkg;

   typedef enum logic [1:0] {
      ST_INIT   = 2'd0,
      ST_WATCH  = 2'd1,
      ST_PASSED = 2'd2,
      ST_FAILED = 2'd3
   } state_t;

   localparam int MAX_NRET = 8;
   localparam int HIT_W    = MAX_NRET;
   localparam int CH_IDX_W = 3;
   localparam int COUNT_W  = 8;
   localparam int POP_W    = 4;

   function automatic logic [POP_W-1:0] popcount_hits(input logic [HIT_W-1:0] v);
      logic [POP_W-1:0] n;
      n = '0;
      for (int i = 0; i < HIT_W; i++) n = n + POP_W'(v[i]);
      return n;
   endfunction

   // Scanning downward leaves the lowest set index as the final assignment.
   function automatic logic [CH_IDX_W-1:0] lowest_index(input logic [HIT_W-1:0] v);
      logic [CH_IDX_W-1:0] idx;
      idx = '0;
      for (int i = HIT_W - 1; i >= 0; i--) if (v[i]) idx = CH_IDX_W'(i);
      return idx;
   endfunction

endpackage

// File: rtl/rvfi_causal_hit.sv
// Per-channel hit detection: a retirement younger than the target that reads
// the target register, or (optionally) loads from the target memory word.
module rvfi_causal_hit #(
   parameter int XLEN      = 32,
   parameter int CHECK_MEM = 0
) (
   input  logic              valid,
   input  logic [63:0]       order,
   input  logic [4:0]        rs1_addr,
   input  logic [4:0]        rs2_addr,
   input  logic [XLEN-3:0]   mem_word,
   input  logic [XLEN/8-1:0] mem_rmask,
   input  logic [63:0]       target_order,
   input  logic [4:0]        target_reg,
   input  logic [XLEN-3:0]   target_word,
   output logic              reg_hit,
   output logic              mem_hit
);

   logic younger;

   assign younger = valid && (order > target_order);
   assign reg_hit = younger && (target_reg != 5'd0) &&
                    ((rs1_addr == target_reg) || (rs2_addr == target_reg));
   assign mem_hit = (CHECK_MEM != 0) && younger && (mem_rmask != '0) &&
                    (mem_word == target_word);

endmodule

// File: rtl/rvfi_causal_multi_check.sv
// Causality checker over NRET RVFI channels: flags any instruction younger than
// the target that consumes the target's result before the target retires.
module rvfi_causal_multi_check
   import rvfi_check_pkg::*;
#(
   parameter int NRET      = 1,
   parameter int XLEN      = 32,
   parameter int CHECK_CH  = 0,
   parameter int CHECK_MEM = 0
) (
   input  logic                     clock,
   input  logic                     resetn,
   input  logic                     check,
   input  logic [NRET-1:0]          rvfi_valid,
   input  logic [64*NRET-1:0]       rvfi_order,
   input  logic [5*NRET-1:0]        rvfi_rs1_addr,
   input  logic [5*NRET-1:0]        rvfi_rs2_addr,
   input  logic [5*NRET-1:0]        rvfi_rd_addr,
   input  logic [XLEN*NRET-1:0]     rvfi_mem_addr,
   input  logic [XLEN/8*NRET-1:0]   rvfi_mem_rmask,
   input  logic [XLEN/8*NRET-1:0]   rvfi_mem_wmask,
   input  logic [63:0]              target_order,
   input  logic [4:0]               target_reg,
   input  logic [XLEN-1:0]          target_addr,
   output logic                     busy,
   output logic                     pass,
   output logic                     fail,
   output logic [CH_IDX_W-1:0]      fail_channel,
   output logic [COUNT_W-1:0]       early_count,
   output state_t                   dbg_state
);

   localparam int MW = XLEN / 8;
   localparam logic [HIT_W-1:0] LOWER_MASK = HIT_W'((1 << CHECK_CH) - 1);

   state_t             state;
   logic [63:0]        lat_order;
   logic [4:0]         lat_reg;
   logic [XLEN-3:0]    lat_word;
   logic               sticky;
   logic [NRET-1:0]    reg_hit, mem_hit;
   logic [HIT_W-1:0]   hit_vec, same_hits;
   logic               qualify;
   logic [COUNT_W:0]   count_sum;
   logic [COUNT_W-1:0] count_next;
   logic               unused_bits;

   for (genvar c = 0; c < NRET; c++) begin : g_hit
      rvfi_causal_hit #(.XLEN(XLEN), .CHECK_MEM(CHECK_MEM)) u_hit (
         .valid        (rvfi_valid[c]),
         .order        (rvfi_order[c*64 +: 64]),
         .rs1_addr     (rvfi_rs1_addr[c*5 +: 5]),
         .rs2_addr     (rvfi_rs2_addr[c*5 +: 5]),
         .mem_word     (rvfi_mem_addr[c*XLEN+2 +: XLEN-2]),
         .mem_rmask    (rvfi_mem_rmask[c*MW +: MW]),
         .target_order (lat_order),
         .target_reg   (lat_reg),
         .target_word  (lat_word),
         .reg_hit      (reg_hit[c]),
         .mem_hit      (mem_hit[c])
      );
   end

   always_comb begin
      hit_vec = '0;
      hit_vec[NRET-1:0] = reg_hit | mem_hit;
   end

   // Only channels older than the checked slot can violate in the retire cycle.
   assign same_hits = hit_vec & LOWER_MASK;

   assign qualify = check && rvfi_valid[CHECK_CH] &&
                    (rvfi_order[CHECK_CH*64 +: 64] == lat_order) &&
                    (((rvfi_rd_addr[CHECK_CH*5 +: 5] == lat_reg) && (lat_reg != 5'd0)) ||
                     ((CHECK_MEM != 0) && (rvfi_mem_wmask[CHECK_CH*MW +: MW] != '0) &&
                      (rvfi_mem_addr[CHECK_CH*XLEN+2 +: XLEN-2] == lat_word)));

   assign count_sum  = {1'b0, early_count} + (COUNT_W+1)'(popcount_hits(hit_vec));
   assign count_next = count_sum[COUNT_W] ? {COUNT_W{1'b1}} : count_sum[COUNT_W-1:0];

   assign busy        = (state == ST_WATCH);
   assign dbg_state   = state;
   assign unused_bits = ^{rvfi_mem_addr, rvfi_mem_wmask, rvfi_rd_addr, target_addr[1:0]};

   always_ff @(posedge clock) begin
      if (!resetn) begin
         state        <= ST_INIT;
         pass         <= 1'b0;
         fail         <= 1'b0;
         fail_channel <= '0;
         early_count  <= '0;
         sticky       <= 1'b0;
         lat_order    <= '0;
         lat_reg      <= '0;
         lat_word     <= '0;
      end else begin
         case (state)
            ST_INIT: begin
               lat_order <= target_order;
               lat_reg   <= target_reg;
               lat_word  <= target_addr[XLEN-1:2];
               state     <= ST_WATCH;
            end
            ST_WATCH: begin
               if (qualify) begin
                  if (sticky || (same_hits != '0)) begin
                     state <= ST_FAILED;
                     fail  <= 1'b1;
                     if (!sticky) fail_channel <= lowest_index(same_hits);
                  end else begin
                     state <= ST_PASSED;
                     pass  <= 1'b1;
                  end
               end else if (hit_vec != '0) begin
                  sticky      <= 1'b1;
                  early_count <= count_next;
                  if (!sticky) fail_channel <= lowest_index(hit_vec);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: doc/rvfi_causal_multi_check.md
RVFI_CAUSAL_MULTI_CHECK -- requirements
Module: rvfi_causal_multi_check

Interface
REQ-001 Parameter NRET, default 1, number of RVFI retire channels (1..8).
REQ-002 Parameter XLEN, default 32, data/address width (32 or 64).
REQ-003 Parameter CHECK_CH, default 0, channel whose retirement defines the target write (0..NRET-1).
REQ-004 Parameter CHECK_MEM, default 0, 1 adds memory-word causality checking to register checking.
REQ-005 Port clock  input  1  sole clock, all state updates on posedge.
REQ-006 Port resetn  input  1  synchronous, active-low reset.
REQ-007 Port check  input  1  cycle in which the target instruction is claimed to retire on CHECK_CH.
REQ-008 Ports rvfi_valid (NRET), rvfi_order (64*NRET), rvfi_rs1_addr/rvfi_rs2_addr/rvfi_rd_addr (5*NRET), rvfi_mem_addr (XLEN*NRET), rvfi_mem_rmask/rvfi_mem_wmask (XLEN/8*NRET)  input  packed per channel, channel c at [c*W +: W].
REQ-009 Ports target_order 64, target_reg 5, target_addr XLEN  input  solver-chosen target, driven by constant-random registers.
REQ-010 Port busy  output  1  high while in WATCH.
REQ-011 Port pass  output  1  sticky, target qualified with no causality violation.
REQ-012 Port fail  output  1  sticky, causality violation proven.
REQ-013 Port fail_channel  output  3  lowest channel index of the first violating retirement.
REQ-014 Port early_count  output  8  saturating count of violating reads seen before qualification.

Function
REQ-015 States: INIT, WATCH, PASSED, FAILED; INIT lasts exactly one cycle, then WATCH.
REQ-016 In INIT, target_order, target_reg, target_addr are latched; later changes on these inputs are ignored.
REQ-017 Per channel c, reg_hit[c] = valid[c] & order[c] > latched order & latched reg != 0 & (rs1[c] == latched reg | rs2[c] == latched reg).
REQ-018 With CHECK_MEM=1, mem_hit[c] = valid[c] & order[c] > latched order & rmask[c] != 0 & mem_addr[c][XLEN-1:2] == latched addr[XLEN-1:2]; with CHECK_MEM=0, mem_hit is 0.
REQ-019 Order comparison is unsigned 64-bit.
REQ-020 In WATCH with check low, any hit on any channel sets the internal sticky flag, records fail_channel if not yet recorded, and adds popcount(reg_hit|mem_hit) to early_count, saturating at 255.
REQ-021 Target qualifies when check=1, valid[CHECK_CH]=1, order[CHECK_CH] == latched order, and either rd[CHECK_CH] == latched reg != 0 or (CHECK_MEM & wmask[CHECK_CH] != 0 & word address matches latched addr).
REQ-022 On the qualifying cycle, only hits on channels c < CHECK_CH count toward same-cycle violations; channels > CHECK_CH are ignored.
REQ-023 Qualifying cycle with sticky flag or same-cycle hit: next state FAILED, fail=1, fail_channel updated if not yet recorded.
REQ-024 Qualifying cycle with no violation: next state PASSED, pass=1.
REQ-025 check high but not qualifying: treated as a check-low cycle for all channels, state stays WATCH.
REQ-026 PASSED and FAILED are terminal until reset; hits are ignored and early_count is frozen.
REQ-027 pass and fail are never high simultaneously; busy = (state == WATCH).

Reset
REQ-028 resetn low at a clock edge forces INIT; pass=0, fail=0, busy=0, fail_channel=0, early_count=0, sticky flag clear, latched targets cleared to 0.
REQ-029 Reset asserted mid-WATCH or in a terminal state discards all history; the first cycle after resetn rises is INIT.

Structure
REQ-030 State enum and hit-vector width constants SHALL live in a shared package rvfi_check_pkg.
REQ-031 A sub-module rvfi_causal_hit SHALL compute reg_hit/mem_hit for one channel, instantiated NRET times by generate.

Verification
REQ-032 NRET=1: target reg 5, order 10; order 12 reads x5, then check with order 10 rd=5 -> fail=1, fail_channel=0, early_count=1.
REQ-033 NRET=2, CHECK_CH=1: same cycle ch0 order 11 rs2=7, ch1 order 10 rd=7 -> fail=1, fail_channel=0.
REQ-034 NRET=2, CHECK_CH=0: ch1 order 11 reads x7 in qualifying cycle, target rd=7 -> pass=1, fail=0.
REQ-035 CHECK_MEM=1: load at 0x1004, order 20, before store to 0x1006, order 15 -> fail=1; load at 0x1008 instead -> pass=1.
REQ-036 300 violating reads then qualify -> early_count=255, fail=1; target_reg=0 -> no reg hits, never qualifies, busy stays 1.
REQ-037 resetn low one cycle during WATCH after 3 hits -> early_count=0, INIT next cycle, later clean qualification -> pass=1.
